// File: rtl/seq_alu.sv
// Multi-cycle ALU: single-cycle FWD/ADD/AND/OR, iterative shift-add MUL and
// bit-serial SLL/SRL/SRA behind a START/BUSY/DONE handshake.
module seq_alu #(
    parameter int unsigned WIDTH = 8,
    localparam int unsigned SHW = $clog2(WIDTH)
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             START,
    input  logic [2:0]       SELECT,
    input  logic [WIDTH-1:0] DATA1,
    input  logic [WIDTH-1:0] DATA2,
    output logic [WIDTH-1:0] RESULT,
    output logic             CARRY,
    output logic             ZERO,
    output logic             BUSY,
    output logic             DONE
);

    localparam logic [2:0] OpFwd = 3'b000;
    localparam logic [2:0] OpAdd = 3'b001;
    localparam logic [2:0] OpAnd = 3'b010;
    localparam logic [2:0] OpOr  = 3'b011;
    localparam logic [2:0] OpMul = 3'b100;
    localparam logic [2:0] OpSll = 3'b101;
    localparam logic [2:0] OpSrl = 3'b110;
    localparam logic [2:0] OpSra = 3'b111;

    typedef enum logic [0:0] {StIdle, StExec} state_e;

    state_e           state_q;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] opa_q, opb_q, acc_q;
    logic [SHW:0]     cnt_q;
    logic [WIDTH-1:0] result_q;
    logic             carry_q, busy_q, done_q;

    logic [WIDTH:0]   sum;
    logic [SHW-1:0]   amt;
    logic [WIDTH-1:0] quick_res;
    logic [WIDTH-1:0] opa_nxt, opb_nxt, acc_nxt, final_res;

    assign sum = {1'b0, DATA1} + {1'b0, DATA2};
    assign amt = DATA2[SHW-1:0];

    // Shift ops with a zero amount fall through to the DATA1 default.
    always_comb begin
        quick_res = DATA1;
        case (SELECT)
            OpFwd:   quick_res = DATA2;
            OpAdd:   quick_res = sum[WIDTH-1:0];
            OpAnd:   quick_res = DATA1 & DATA2;
            OpOr:    quick_res = DATA1 | DATA2;
            default: quick_res = DATA1;
        endcase
    end

    always_comb begin
        opa_nxt = opa_q;
        opb_nxt = opb_q;
        acc_nxt = acc_q;
        case (op_q)
            OpMul: begin
                if (opb_q[0]) acc_nxt = acc_q + opa_q;
                opa_nxt = opa_q << 1;
                opb_nxt = opb_q >> 1;
            end
            OpSll:   opa_nxt = opa_q << 1;
            OpSrl:   opa_nxt = opa_q >> 1;
            OpSra:   opa_nxt = {opa_q[WIDTH-1], opa_q[WIDTH-1:1]};
            default: ;
        endcase
        final_res = (op_q == OpMul) ? acc_nxt : opa_nxt;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q  <= StIdle;
            op_q     <= OpFwd;
            opa_q    <= '0;
            opb_q    <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    done_q <= 1'b0;
                    if (START) begin
                        op_q  <= SELECT;
                        opa_q <= DATA1;
                        opb_q <= DATA2;
                        acc_q <= '0;
                        if (SELECT == OpMul) begin
                            cnt_q   <= (SHW+1)'(WIDTH);
                            busy_q  <= 1'b1;
                            state_q <= StExec;
                        end else if (SELECT[2] && (amt != '0)) begin
                            cnt_q   <= {1'b0, amt};
                            busy_q  <= 1'b1;
                            state_q <= StExec;
                        end else begin
                            result_q <= quick_res;
                            carry_q  <= (SELECT == OpAdd) && sum[WIDTH];
                            done_q   <= 1'b1;
                        end
                    end
                end
                StExec: begin
                    opa_q <= opa_nxt;
                    opb_q <= opb_nxt;
                    acc_q <= acc_nxt;
                    cnt_q <= cnt_q - 1'b1;
                    // Working registers stay private until the last iteration.
                    if (cnt_q == (SHW+1)'(1)) begin
                        result_q <= final_res;
                        carry_q  <= 1'b0;
                        done_q   <= 1'b1;
                        busy_q   <= 1'b0;
                        state_q  <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign RESULT = result_q;
    assign CARRY  = carry_q;
    assign ZERO   = ~|result_q;
    assign BUSY   = busy_q;
    assign DONE   = done_q;

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu: WIDTH=8 and WIDTH=16 instances share clock and reset.
module tb_seq_alu;

    localparam logic [2:0] OpFwd = 3'b000;
    localparam logic [2:0] OpAdd = 3'b001;
    localparam logic [2:0] OpAnd = 3'b010;
    localparam logic [2:0] OpOr  = 3'b011;
    localparam logic [2:0] OpMul = 3'b100;
    localparam logic [2:0] OpSll = 3'b101;
    localparam logic [2:0] OpSrl = 3'b110;
    localparam logic [2:0] OpSra = 3'b111;

    logic        clk = 1'b0;
    logic        rst, start8, start16;
    logic [2:0]  sel;
    logic [15:0] d1, d2;
    logic [7:0]  res8;
    logic [15:0] res16;
    logic        c8, z8, b8, dn8, c16, z16, b16, dn16;

    int unsigned checks = 0;
    int unsigned errors = 0;
    logic [16:0] q8[$];
    logic [16:0] q16[$];
    logic [15:0] last8, last16;

    always #5 clk = ~clk;

    seq_alu #(.WIDTH(8)) dut8 (
        .CLK(clk), .RESET(rst), .START(start8), .SELECT(sel),
        .DATA1(d1[7:0]), .DATA2(d2[7:0]),
        .RESULT(res8), .CARRY(c8), .ZERO(z8), .BUSY(b8), .DONE(dn8)
    );

    seq_alu #(.WIDTH(16)) dut16 (
        .CLK(clk), .RESET(rst), .START(start16), .SELECT(sel),
        .DATA1(d1), .DATA2(d2),
        .RESULT(res16), .CARRY(c16), .ZERO(z16), .BUSY(b16), .DONE(dn16)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: returns {carry, result} using plain arithmetic operators.
    function automatic logic [16:0] model(input int w, input logic [2:0] op,
                                          input logic [15:0] a, input logic [15:0] b);
        logic [31:0] m, x, y, r;
        int          n;
        logic        c;
        m = (32'd1 << w) - 32'd1;
        x = {16'd0, a} & m;
        y = {16'd0, b} & m;
        n = int'(y) & (w - 1);
        c = 1'b0;
        case (op)
            OpFwd: r = y;
            OpAdd: begin r = x + y; c = r[w]; end
            OpAnd: r = x & y;
            OpOr:  r = x | y;
            OpMul: r = x * y;
            OpSll: r = x << n;
            OpSrl: r = x >> n;
            default: begin
                r = x >> n;
                if (x[w-1]) r = r | (m & ~(m >> n));
            end
        endcase
        r = r & m;
        return {c, r[15:0]};
    endfunction

    always @(posedge clk) begin : mon8
        logic [16:0] e;
        #1;
        if (dn8 === 1'b1) begin
            if (q8.size() == 0) check_eq("done8_unexpected", 32'(dn8), 32'd0);
            else begin
                e = q8.pop_front();
                check_eq("res8", 32'(res8), 32'(e[7:0]));
                check_eq("carry8", 32'(c8), 32'(e[16]));
                check_eq("zero8", 32'(z8), 32'(e[7:0] == 8'd0));
            end
        end
    end

    always @(posedge clk) begin : mon16
        logic [16:0] e;
        #1;
        if (dn16 === 1'b1) begin
            if (q16.size() == 0) check_eq("done16_unexpected", 32'(dn16), 32'd0);
            else begin
                e = q16.pop_front();
                check_eq("res16", 32'(res16), 32'(e[15:0]));
                check_eq("carry16", 32'(c16), 32'(e[16]));
                check_eq("zero16", 32'(z16), 32'(e[15:0] == 16'd0));
            end
        end
    end

    // Issue one op; checks BUSY/DONE timing and that RESULT holds while busy.
    task automatic run(input bit w16, input logic [2:0] op, input logic [15:0] a,
                       input logic [15:0] b, input bit poke);
        int          w, n, ed;
        logic [16:0] e;
        logic [15:0] rs;
        logic        bs, dn;
        w  = w16 ? 16 : 8;
        e  = model(w, op, a, b);
        n  = int'(b) & (w - 1);
        ed = (op == OpMul) ? w : (op[2] ? n : 0);
        @(negedge clk);
        sel = op; d1 = a; d2 = b;
        if (w16) begin start16 = 1'b1; q16.push_back(e); end
        else begin start8 = 1'b1; q8.push_back(e); end
        for (int i = 0; i <= ed; i++) begin
            @(posedge clk); #1;
            start8 = 1'b0; start16 = 1'b0;
            if (i == 0) begin
                sel = 3'($urandom); d1 = 16'($urandom); d2 = 16'($urandom);
            end
            if (poke && i == 1 && ed > 2) begin
                sel = OpAdd;
                if (w16) start16 = 1'b1; else start8 = 1'b1;
            end
            rs = w16 ? res16 : {8'd0, res8};
            bs = w16 ? b16 : b8;
            dn = w16 ? dn16 : dn8;
            check_eq("busy", 32'(bs), 32'(i < ed));
            check_eq("done", 32'(dn), 32'(i == ed));
            if (i < ed) check_eq("hold", 32'(rs), 32'(w16 ? last16 : last8));
        end
        if (w16) last16 = e[15:0]; else last8 = e[15:0];
    endtask

    initial begin
        rst = 1'b1; start8 = 1'b0; start16 = 1'b0; sel = '0; d1 = '0; d2 = '0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_res8", 32'(res8), 32'd0);
        check_eq("rst_zero8", 32'(z8), 32'd1);
        check_eq("rst_busy8", 32'(b8), 32'd0);
        check_eq("rst_done8", 32'(dn8), 32'd0);
        check_eq("rst_res16", 32'(res16), 32'd0);
        check_eq("rst_zero16", 32'(z16), 32'd1);
        rst = 1'b0;
        last8 = '0; last16 = '0;

        run(1'b0, OpAdd, 16'd12, 16'd2, 1'b0);
        @(posedge clk); #1;
        check_eq("add_done_pulse", 32'(dn8), 32'd0);

        // ADD with carry followed back-to-back by FWD.
        @(negedge clk);
        sel = OpAdd; d1 = 16'h00FF; d2 = 16'h0001; start8 = 1'b1;
        q8.push_back(17'h1_0000);
        @(posedge clk); #1;
        check_eq("b2b_done_a", 32'(dn8), 32'd1);
        sel = OpFwd; d2 = 16'h00A5;
        q8.push_back(17'h0_00A5);
        @(posedge clk); #1;
        check_eq("b2b_done_b", 32'(dn8), 32'd1);
        start8 = 1'b0;
        @(posedge clk); #1;
        check_eq("b2b_done_end", 32'(dn8), 32'd0);
        last8 = 16'h00A5;

        run(1'b0, OpMul, 16'd13, 16'd11, 1'b1);
        run(1'b0, OpMul, 16'h10, 16'h10, 1'b1);
        run(1'b0, OpSra, 16'h90, 16'd3, 1'b0);
        run(1'b0, OpSrl, 16'h90, 16'd3, 1'b0);
        run(1'b0, OpSll, 16'h90, 16'd3, 1'b0);
        run(1'b0, OpSll, 16'h90, 16'hF8, 1'b0);
        run(1'b0, OpOr, 16'h35, 16'h0A, 1'b0);
        run(1'b0, OpSra, 16'h4C, 16'd1, 1'b0);

        // Reset during the 4th busy cycle of a MUL aborts it without a DONE.
        @(negedge clk);
        sel = OpMul; d1 = 16'd13; d2 = 16'd11; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check_eq("abort_res8", 32'(res8), 32'd0);
        check_eq("abort_zero8", 32'(z8), 32'd1);
        check_eq("abort_busy8", 32'(b8), 32'd0);
        check_eq("abort_done8", 32'(dn8), 32'd0);
        rst = 1'b0;
        last8 = '0; last16 = '0;
        repeat (12) @(posedge clk);
        run(1'b0, OpAnd, 16'h0F, 16'h3C, 1'b0);

        run(1'b1, OpMul, 16'h0100, 16'h0003, 1'b1);
        run(1'b1, OpSra, 16'h8000, 16'd15, 1'b0);
        run(1'b1, OpAdd, 16'hFFF0, 16'h0020, 1'b0);
        run(1'b1, OpMul, 16'h1234, 16'h0056, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        check_eq("sb8_empty", 32'(q8.size()), 32'd0);
        check_eq("sb16_empty", 32'(q16.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
